// File: rtl/dcache_mem_ctrl.sv
// Memory-side responder for the data cache miss port: sequences a line fill or
// write-back over a byte-wide RAM port and returns a one-cycle completion pulse.
module dcache_mem_ctrl #(
  parameter  int unsigned BLOCK_WIDTH = 4,
  localparam int unsigned BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  input  logic                      rdyIn,
  input  logic                      miss,
  input  logic [31-BLOCK_WIDTH:0]   missAddr,
  input  logic                      readWriteIn,
  input  logic [BLOCK_SIZE*8-1:0]   writeBackIn,
  output logic                      memDataValid,
  output logic [31-BLOCK_WIDTH:0]   memAddr,
  output logic [BLOCK_SIZE*8-1:0]   memDataOut,
  output logic                      acceptWrite,
  input  logic [7:0]                memDIn,
  output logic [31:0]               memAOut,
  output logic [7:0]                memDOut,
  output logic                      memWrOut
);

  localparam int unsigned LINE_W = 32 - BLOCK_WIDTH;
  localparam int unsigned DATA_W = BLOCK_SIZE * 8;
  localparam int unsigned LAST   = BLOCK_SIZE - 1;

  typedef enum logic [2:0] {
    IDLE, READ, READ_LAST, WRITE, RESP, COOLDOWN
  } state_t;

  state_t                   state_q, state_d;
  logic [BLOCK_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc, cnt_dec;
  logic [LINE_W-1:0]        line_q, line_d;
  logic [DATA_W-1:0]        wb_q, wb_d;
  logic [DATA_W-1:0]        buf_q, buf_d;
  logic [31:0]              a_q, a_d;
  logic [7:0]               d_q, d_d;
  logic                     wr_q, wr_d;
  logic                     valid_q, valid_d;
  logic                     accept_q, accept_d;
  logic [LINE_W-1:0]        maddr_q, maddr_d;
  logic [DATA_W-1:0]        mdata_q, mdata_d;

  // Next-state and next-output logic; RAM address/data are set up one edge
  // ahead so they are stable for the whole cycle of the byte they belong to.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    wb_d     = wb_q;
    buf_d    = buf_q;
    a_d      = a_q;
    d_d      = d_q;
    wr_d     = 1'b0;
    valid_d  = 1'b0;
    accept_d = 1'b0;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    cnt_inc  = cnt_q + BLOCK_WIDTH'(1);
    cnt_dec  = cnt_q - BLOCK_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (miss) begin
          line_d = missAddr;
          wb_d   = writeBackIn;
          cnt_d  = '0;
          a_d    = {missAddr, BLOCK_WIDTH'(0)};
          if (readWriteIn) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
            d_d     = writeBackIn[7:0];
            wr_d    = 1'b1;
          end
        end
      end
      READ: begin
        // RAM data lags its address by one cycle, so this cycle returns byte cnt-1
        if (cnt_q != '0) begin
          buf_d[{cnt_dec, 3'b000} +: 8] = memDIn;
        end
        if (cnt_q == BLOCK_WIDTH'(LAST)) begin
          state_d = READ_LAST;
        end else begin
          cnt_d = cnt_inc;
          a_d   = {line_q, cnt_inc};
        end
      end
      READ_LAST: begin
        buf_d[DATA_W-1 -: 8] = memDIn;
        mdata_d = buf_d;
        maddr_d = line_q;
        valid_d = 1'b1;
        state_d = RESP;
      end
      WRITE: begin
        if (cnt_q == BLOCK_WIDTH'(LAST)) begin
          maddr_d  = line_q;
          accept_d = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_inc;
          a_d   = {line_q, cnt_inc};
          d_d   = wb_q[{cnt_inc, 3'b000} +: 8];
          wr_d  = 1'b1;
        end
      end
      RESP:     state_d = COOLDOWN;
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and output registers; a low rdyIn freezes everything in place.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      wb_q     <= '0;
      buf_q    <= '0;
      a_q      <= '0;
      d_q      <= '0;
      wr_q     <= 1'b0;
      valid_q  <= 1'b0;
      accept_q <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= '0;
    end else if (rdyIn) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      wb_q     <= wb_d;
      buf_q    <= buf_d;
      a_q      <= a_d;
      d_q      <= d_d;
      wr_q     <= wr_d;
      valid_q  <= valid_d;
      accept_q <= accept_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
    end
  end

  // Strobes are masked while stalled; the held registers replay them on release.
  assign memWrOut     = wr_q & rdyIn;
  assign memDataValid = valid_q & rdyIn;
  assign acceptWrite  = accept_q & rdyIn;
  assign memAOut      = a_q;
  assign memDOut      = d_q;
  assign memAddr      = maddr_q;
  assign memDataOut   = mdata_q;

endmodule
